// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier that borrows the pipeline's shared ALU,
// stalling the pipeline for the 64 ADD/SHIFT cycles it owns the ALU.
`ifndef EXE_ADD
`define EXE_ADD 4'h0
`endif
`ifndef EXE_SUB
`define EXE_SUB 4'h1
`endif
`ifndef EXE_SLL
`define EXE_SLL 4'h5
`endif

module alu_mul_seq #(
    parameter int WIDTH  = 32,
    parameter int LENGTH = 4
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              start,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    input  logic [WIDTH-1:0]  ex_a,
    input  logic [WIDTH-1:0]  ex_b,
    input  logic [LENGTH-1:0] ex_cmd,
    input  logic [WIDTH-1:0]  alu_result,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [LENGTH-1:0] alu_cmd,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [WIDTH-1:0]  product
);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [4:0]        cnt;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  mplier;

    // Datapath registers; a start is only accepted while the ALU is free.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= src_a;
                        mplier <= src_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                ADD: begin
                    acc <= alu_result;
                end
                SHIFT: begin
                    mcand  <= alu_result;
                    mplier <= mplier >> 1;
                    if (cnt == 5'd31) begin
                        product <= acc;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state plus ALU steering; ex_* passes through whenever the ALU is free.
    always_comb begin
        state_next = state;
        alu_a      = ex_a;
        alu_b      = ex_b;
        alu_cmd    = ex_cmd;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ADD;
            end
            ADD: begin
                busy       = 1'b1;
                alu_cmd    = LENGTH'(`EXE_ADD);
                alu_a      = acc;
                alu_b      = mplier[0] ? mcand : '0;
                state_next = SHIFT;
            end
            SHIFT: begin
                busy       = 1'b1;
                alu_cmd    = LENGTH'(`EXE_SLL);
                alu_a      = mcand;
                alu_b      = WIDTH'(1);
                state_next = (cnt == 5'd31) ? DONE : ADD;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? ADD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign stall = busy;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq, with a behavioural shared ALU
// wired to the alu_* ports.
`ifndef EXE_ADD
`define EXE_ADD 4'h0
`endif
`ifndef EXE_SUB
`define EXE_SUB 4'h1
`endif
`ifndef EXE_SLL
`define EXE_SLL 4'h5
`endif

module tb_alu_mul_seq;

    localparam int WIDTH  = 32;
    localparam int LENGTH = 4;

    logic              clock = 1'b0;
    logic              nReset;
    logic              start;
    logic [WIDTH-1:0]  src_a, src_b, ex_a, ex_b;
    logic [LENGTH-1:0] ex_cmd;
    logic [WIDTH-1:0]  alu_result, alu_a, alu_b, product;
    logic [LENGTH-1:0] alu_cmd;
    logic              busy, stall, done;

    int checks = 0;
    int fails  = 0;

    alu_mul_seq #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
        .clock(clock), .nReset(nReset), .start(start),
        .src_a(src_a), .src_b(src_b), .ex_a(ex_a), .ex_b(ex_b), .ex_cmd(ex_cmd),
        .alu_result(alu_result), .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
        .busy(busy), .stall(stall), .done(done), .product(product)
    );

    always #5 clock = ~clock;

    // Shared ALU model.
    always_comb begin
        alu_result = '0;
        case (alu_cmd)
            `EXE_ADD: alu_result = alu_a + alu_b;
            `EXE_SUB: alu_result = alu_a - alu_b;
            `EXE_SLL: alu_result = alu_a << alu_b[4:0];
            default:  alu_result = '0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Caller is at a negedge; launches a multiply and waits for done.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 output int doneAt, output int busyCycles,
                                 output logic [31:0] firstAlu);
        src_a = a;
        src_b = b;
        start = 1'b1;
        doneAt = -1;
        busyCycles = 0;
        firstAlu = '0;
        @(posedge clock);
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            start = 1'b0;
            if (n == 0) firstAlu = alu_result;
            if (busy) busyCycles++;
            if (done) begin
                doneAt = n;
                break;
            end
        end
    endtask

    initial begin
        int          doneAt, busyCycles, doneCount, d1, d2;
        logic [31:0] firstAlu, p1, p2, pAtDone;

        nReset = 1'b0;
        start  = 1'b0;
        src_a  = '0;
        src_b  = '0;
        ex_a   = 32'd10;
        ex_b   = 32'd3;
        ex_cmd = `EXE_SUB;
        #3;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_stall", {31'd0, stall}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_product", product, 32'd0);

        @(negedge clock);
        nReset = 1'b1;
        #1;
        checkOutput("idle_sub_result", alu_result, 32'd7);
        checkOutput("idle_sub_cmd", {28'd0, alu_cmd}, {28'd0, `EXE_SUB});
        checkOutput("idle_stall", {31'd0, stall}, 32'd0);

        @(negedge clock);
        $display("[TB] 6*7");
        applyStimulus(32'd6, 32'd7, doneAt, busyCycles, firstAlu);
        checkOutput("mul6x7_first_add", firstAlu, 32'd6);
        checkOutput("mul6x7_done_at", doneAt, 32'd64);
        checkOutput("mul6x7_busy_cycles", busyCycles, 32'd64);
        checkOutput("mul6x7_product", product, 32'd42);
        @(negedge clock);
        checkOutput("mul6x7_done_pulse", {31'd0, done}, 32'd0);
        checkOutput("mul6x7_product_held", product, 32'd42);

        $display("[TB] overflow operands");
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, doneAt, busyCycles, firstAlu);
        checkOutput("mulmax_done_at", doneAt, 32'd64);
        checkOutput("mulmax_product", product, 32'h0000_0001);
        @(negedge clock);
        applyStimulus(32'h0001_0000, 32'h0001_0000, doneAt, busyCycles, firstAlu);
        checkOutput("mul2p16_done_at", doneAt, 32'd64);
        checkOutput("mul2p16_product", product, 32'h0000_0000);

        // Start raised mid-operation must be ignored.
        @(negedge clock);
        $display("[TB] start during run");
        src_a = 32'd6;
        src_b = 32'd7;
        start = 1'b1;
        doneAt = -1;
        doneCount = 0;
        pAtDone = '0;
        @(posedge clock);
        for (int n = 0; n < 150; n++) begin
            @(negedge clock);
            start = (n == 10);
            if (n == 10) begin
                src_a = 32'd2;
                src_b = 32'd2;
            end
            if (done) begin
                doneCount++;
                if (doneAt < 0) begin
                    doneAt = n;
                    pAtDone = product;
                end
            end
        end
        checkOutput("midstart_done_at", doneAt, 32'd64);
        checkOutput("midstart_product", pAtDone, 32'd42);
        checkOutput("midstart_done_count", doneCount, 32'd1);

        // Reset asserted mid-operation.
        $display("[TB] reset during run");
        ex_a = 32'h55;
        ex_b = 32'd3;
        ex_cmd = `EXE_SUB;
        src_a = 32'd3;
        src_b = 32'd5;
        start = 1'b1;
        @(posedge clock);
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            start = 1'b0;
        end
        checkOutput("prereset_busy", {31'd0, busy}, 32'd1);
        nReset = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_product", product, 32'd0);
        checkOutput("abort_alu_result", alu_result, 32'h52);
        @(posedge clock);
        @(negedge clock);
        checkOutput("abort_busy_held", {31'd0, busy}, 32'd0);
        nReset = 1'b1;
        applyStimulus(32'd3, 32'd5, doneAt, busyCycles, firstAlu);
        checkOutput("postreset_done_at", doneAt, 32'd64);
        checkOutput("postreset_product", product, 32'd15);

        // Start held high: back-to-back multiplies.
        @(negedge clock);
        $display("[TB] back-to-back");
        ex_a = 32'd10;
        ex_b = 32'd3;
        ex_cmd = `EXE_SUB;
        src_a = 32'd3;
        src_b = 32'd5;
        start = 1'b1;
        d1 = -1;
        d2 = -1;
        p1 = '0;
        p2 = '0;
        @(posedge clock);
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (n == 0) begin
                src_a = 32'd4;
                src_b = 32'd4;
            end
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    p1 = product;
                    checkOutput("b2b_done_passthrough", alu_result, 32'd7);
                    checkOutput("b2b_done_stall", {31'd0, stall}, 32'd0);
                end else begin
                    d2 = n;
                    p2 = product;
                    start = 1'b0;
                    break;
                end
            end
        end
        checkOutput("b2b_first_done_at", d1, 32'd64);
        checkOutput("b2b_first_product", p1, 32'd15);
        checkOutput("b2b_gap", d2 - d1, 32'd65);
        checkOutput("b2b_second_product", p2, 32'd16);
        @(negedge clock);
        checkOutput("b2b_idle_done", {31'd0, done}, 32'd0);
        checkOutput("b2b_idle_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter LENGTH, default 4, ALU command width in bits; the encodings are the `EXE_* codes from alucodes.sv.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  rising-edge system clock.
REQ-005 nReset  in  1  asynchronous active-low reset.
REQ-006 start  in  1  multiply request; sampled on rising edges only.
REQ-007 src_a  in  WIDTH  multiplicand.
REQ-008 src_b  in  WIDTH  multiplier.
REQ-009 ex_a, ex_b  in  WIDTH each  pipeline EX-stage ALU operands.
REQ-010 ex_cmd  in  LENGTH  pipeline EX-stage ALU command.
REQ-011 alu_result  in  WIDTH  combinational result returned from the shared ALU.
REQ-012 alu_a, alu_b  out  WIDTH each  operands driven to the shared ALU.
REQ-013 alu_cmd  out  LENGTH  command driven to the shared ALU.
REQ-014 busy  out  1  high while the sequencer owns the ALU.
REQ-015 stall  out  1  stall request to the pipeline; equal to busy.
REQ-016 done  out  1  one-cycle pulse; product valid.
REQ-017 product  out  WIDTH  low WIDTH bits of src_a*src_b; held until the next completion.

Function
REQ-018 The FSM SHALL have exactly four states, IDLE, ADD, SHIFT and DONE, plus a 5-bit iteration counter cnt.
REQ-019 In IDLE or DONE, alu_a/alu_b/alu_cmd SHALL equal ex_a/ex_b/ex_cmd combinationally, and busy=stall=0.
REQ-020 In IDLE or DONE, start=1 at an edge SHALL load mcand=src_a, mplier=src_b, acc=0, cnt=0 and move the FSM to ADD.
REQ-021 In IDLE, start=0 SHALL hold the FSM in IDLE; in DONE, start=0 SHALL move the FSM to IDLE.
REQ-022 In ADD, outputs SHALL be alu_cmd=`EXE_ADD, alu_a=acc, and alu_b=mcand if mplier[0]=1 (else 0); acc SHALL load alu_result at the edge, and the next state SHALL be SHIFT.
REQ-023 In SHIFT, outputs SHALL be alu_cmd=`EXE_SLL, alu_a=mcand, alu_b=1; mcand SHALL load alu_result and mplier SHALL shift right 1 with zero fill.
REQ-024 In SHIFT with cnt/=31, the FSM SHALL go to ADD with cnt+1; with cnt=31 it SHALL go to DONE and load product=acc.
REQ-025 In ADD and SHIFT, busy=stall=1, and ex_* SHALL be ignored.
REQ-026 done SHALL be 1 only in DONE.
REQ-027 Latency SHALL be fixed: done is high in the cycle following the 64th rising edge after the edge that accepted start, independent of operand values, with no early termination.
REQ-028 start while in ADD or SHIFT SHALL be ignored, with no queuing and no effect on the current operation.
REQ-029 Arithmetic SHALL be unsigned and modulo 2^WIDTH; overflow bits SHALL be discarded and no flag produced.
REQ-030 A start accepted in DONE (back-to-back) SHALL still pulse done for that DONE cycle, and product SHALL update 64 edges later.
REQ-031 All state SHALL be held in flops updated on the clock rising edge; all ALU-facing outputs SHALL be combinational from state and registers.

Reset
REQ-032 nReset=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, cnt=0, acc=mcand=mplier=0, product=0, done=0, busy=stall=0.
REQ-033 Reset asserted mid-operation SHALL abort it: no done pulse, product=0, and ALU ownership returns to ex_* immediately.
REQ-034 After nReset rises, the first start SHALL be honoured at the first rising edge.

Verification (bench instantiates alu_mul_seq plus the team ALU, wired alu_* <-> ALU)
REQ-035 start with src_a=6, src_b=7 -> done after 64 edges, product=42, busy high for exactly 64 cycles.
REQ-036 src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> product=0x00000001; src_a=0x00010000, src_b=0x00010000 -> product=0x00000000.
REQ-037 Idle with ex_cmd=`EXE_SUB, ex_a=10, ex_b=3 -> alu_result=7 in the same cycle, stall=0.
REQ-038 start=1 on cycle 10 of a running 6*7 multiply with src_a=2, src_b=2 -> result still 42 at the original done time, and no second done.
REQ-039 nReset pulsed low at cycle 20 of 3*5 -> outputs reset asynchronously, no done pulse; a new 3*5 then gives 15.
REQ-040 start held high continuously with 3*5 then 4*4 -> done pulses 65 cycles apart with product=15 then 16.
